// File: rtl/inv_key_schedule_if.sv
// inv_key_schedule_if
//   Handshake and key bus between the inverse key schedule and its neighbours.
//   Parameters:
//     NK     - key length in 32-bit words (4, 6 or 8)
//     RWIDTH - width of rk_round
//   Signals:
//     start    - load key_in and begin a schedule (producer -> schedule)
//     key_in   - last NK words of the forward expansion, lowest index in MSBs
//     busy     - schedule is running
//     rk_valid - rk holds a round key
//     rk_ready - consumer accepts rk
//     rk       - round key, w[4r] in bits [127:96]
//     rk_round - round number r of rk
//     rk_last  - high with the round-0 key
//   Modports: master drives start/key_in/rk_ready, slave is the schedule.
interface inv_key_schedule_if #(
  parameter int NK     = 4,
  parameter int RWIDTH = 4
) ();
  logic                start;
  logic [32*NK-1:0]    key_in;
  logic                busy;
  logic                rk_valid;
  logic                rk_ready;
  logic [127:0]        rk;
  logic [RWIDTH-1:0]   rk_round;
  logic                rk_last;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk, rk_round, rk_last
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk, rk_round, rk_last
  );
endinterface

// File: rtl/inv_key_schedule.sv
// inv_key_schedule
//   Inverse AES key schedule for AES-128/192/256 (NK = 4/6/8). Loads the last
//   NK words of the forward expansion and emits round keys Nr down to 0, one
//   per rk_valid/rk_ready handshake, walking the expansion backwards with
//   w[j] = w[j+NK] ^ g(w[j+NK-1], j+NK).
//   Ports:
//     clk   - system clock
//     reset - asynchronous, active-low reset
//     bus   - inv_key_schedule_if.slave (start, key_in, busy, rk_valid,
//             rk_ready, rk, rk_round, rk_last)
//   Optional build macro INV_KEY_ZEROIZE_EN: clears window and lo when the
//   final key is accepted so no key material remains in flops while idle.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; window holds last contents (or zero)
//   RUN   | presenting round key r, stepping the window backwards
module inv_key_schedule #(
  parameter int NK     = 4,
  parameter int RWIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  inv_key_schedule_if.slave bus
);
  localparam int                NR       = NK + 6;
  localparam int                LO_W     = 7;
  localparam logic [LO_W-1:0]   LO_START = LO_W'(4*NR + 4 - NK);
  localparam logic [RWIDTH-1:0] R_START  = RWIDTH'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NK-1:0][31:0]    win_q, win_d;   // win_q[k] = w[lo + k]
  logic [NK+3:0][31:0]    ext;            // ext[e]   = w[lo - 4 + e]
  logic [LO_W-1:0]        lo_q, lo_d;
  logic [RWIDTH-1:0]      r_q, r_d;
  logic [127:0]           rk_mux;
  logic                   hs;
  logic                   step;

  function automatic logic [7:0] rcon(input int k);
    case (k)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [31:0] g_fn(input logic [31:0] x, input int i);
    if (i % NK == 0)
      return sub_word({x[23:0], x[31:24]}) ^ {rcon(i / NK), 24'h000000};
    else if (NK == 8 && i % NK == 4)
      return sub_word(x);
    else
      return x;
  endfunction

  // Four older words, chained: each new word uses the one just above it.
  // When lo < 4 the lowest entries are meaningless and are never shifted in.
  function automatic logic [NK+3:0][31:0] extend(input logic [NK-1:0][31:0] win,
                                                  input logic [LO_W-1:0]   lo);
    logic [NK+3:0][31:0] e_w;
    e_w = '0;
    for (int k = 0; k < NK; k++)
      e_w[k+4] = win[k];
    for (int e = 3; e >= 0; e--)
      e_w[e] = e_w[e+NK] ^ g_fn(e_w[e+NK-1], int'(lo) + NK - 4 + e);
    return e_w;
  endfunction

  assign ext  = extend(win_q, lo_q);
  assign hs   = (state_q == RUN) && bus.rk_ready;
  // Step only when the next key's words are not already in the window.
  assign step = hs && (r_q != '0) && ((4 * (int'(r_q) - 1)) < int'(lo_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lo_d    = lo_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          for (int k = 0; k < NK; k++)
            win_d[k] = bus.key_in[32*(NK-1-k) +: 32];
          lo_d = LO_START;
          r_d  = R_START;
        end
      end
      RUN: begin
        if (hs) begin
          if (r_q == '0) begin
            state_d = IDLE;
`ifdef INV_KEY_ZEROIZE_EN
            win_d = '0;
            lo_d  = '0;
`endif
          end else begin
            r_d = r_q - RWIDTH'(1);
            if (step) begin
              for (int k = 0; k < NK; k++) begin
                win_d[k] = ext[k];
                for (int m = 1; m < 4; m++)
                  if (lo_q == LO_W'(m)) win_d[k] = ext[4-m+k];
              end
              lo_d = (lo_q < LO_W'(4)) ? '0 : lo_q - LO_W'(4);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q <= '0;
      lo_q  <= '0;
      r_q   <= '0;
    end else begin
      win_q <= win_d;
      lo_q  <= lo_d;
      r_q   <= r_d;
    end
  end

  // Key r sits at window offset 4r - lo, which stays within 0..NK-4.
  always_comb begin
    rk_mux = {win_q[0], win_q[1], win_q[2], win_q[3]};
    for (int k = 0; k <= NK - 4; k++)
      if ((4 * int'(r_q) - int'(lo_q)) == k)
        rk_mux = {win_q[k], win_q[k+1], win_q[k+2], win_q[k+3]};
  end

  assign bus.rk       = rk_mux;
  assign bus.rk_round = r_q;
  assign bus.rk_valid = (state_q == RUN);
  assign bus.busy     = (state_q == RUN);
  assign bus.rk_last  = (state_q == RUN) && (r_q == '0);
endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Parametrised inverse AES key schedule covering AES-128, AES-192 and AES-256 through parameter NK.
- Takes the last NK words of the forward key expansion and emits round keys in decryption order, round Nr down to round 0, one 128-bit key per valid/ready handshake.
- Sits between key storage and the inverse-cipher datapath; replaces the fixed 128-bit, free-running inverse expander.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8. Derived Nr = NK+6 (10/12/14 rounds).
- RWIDTH, 4, width of rk_round.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  load key_in and begin a schedule; honoured only in IDLE.
- key_in  input  32*NK  forward words w[4Nr+4-NK]..w[4Nr+3]; lowest index in the MSBs.
- busy  output  1  high in RUN.
- rk_valid  output  1  rk holds a round key.
- rk_ready  input  1  consumer accepts rk.
- rk  output  128  round key; w[4r] in bits [127:96].
- rk_round  output  RWIDTH  round number r of rk.
- rk_last  output  1  high with the round-0 key.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE, window cleared, busy=0, rk_valid=0, rk=0, rk_round=0, rk_last=0.
- States: IDLE -> RUN on start. RUN -> IDLE on the handshake with rk_last=1. There are no other transitions.
- The window is a register of NK words w[lo]..w[lo+NK-1]. lo is a word-index counter.
- Start accept: window <= key_in; lo <= 4Nr+4-NK; r <= Nr. rk_valid rises the next cycle.
- rk and rk_round are driven combinationally from the window and r. rk_valid = (state==RUN).
- Handshake (rk_valid & rk_ready):
  - r <= r-1.
  - If 4(r-1) < lo, a step fires in the same cycle. Result: one key per cycle when rk_ready is held high.
- Step: derives n = min(4, lo) new words w[lo-1] down to w[lo-n], chained combinationally.
  - Per word: w[j] = w[j+NK] ^ g(w[j+NK-1], j+NK).
  - g for i mod NK == 0: SubWord(RotWord(x)) ^ Rcon[i/NK].
  - g for NK==8 and i mod 8 == 4: SubWord(x).
  - g otherwise: x.
  - Rcon comes from a 10-entry table (01,02,04,...,1b,36 in the top byte).
  - Window then holds w[lo-n]..w[lo-n+NK-1]; lo <= lo-n.
- Steps never take lo below 0. At r=0, w[0..3] equal the original cipher key's first 4 words.
- Holding: while rk_valid & !rk_ready, rk, rk_round and rk_last stay stable.
- start during RUN is ignored, with no restart.
- Reset mid-schedule aborts immediately to the reset values.
- After rk_last is accepted, the block is back in IDLE. start may be asserted that cycle; it is sampled only in IDLE, so the earliest new start is accepted the following cycle.

Optional Feature:
- Macro: INV_KEY_ZEROIZE_EN.
- Defined: on the rk_last handshake, and on any reset, the window, rk and lo are cleared to 0. No key material stays in flops in IDLE.
- Undefined: the window holds its final contents (w[0..NK-1]) in IDLE. rk is undefined-but-stable in IDLE.

Test Plan:
- NK=4, key_in=d014f9a8 c9ee2589 e13f0cc8 b6630ca6, rk_ready=1.
  - Cycle 1: rk=d014...0ca6, rk_round=10.
  - Cycle 2: rk=ac7766f3 19fadc21 28d12941 575c006e, rk_round=9.
  - Cycle 11: rk=2b7e1516 28aed2a6 abf71588 09cf4f3c with rk_last=1.
- NK=6, key_in = last 6 words of the forward expansion of 000102...1617 (golden model), rk_ready=1.
  - 13 keys emitted, all matching the model in reverse order.
  - Final key 00010203 04050607 08090a0b 0c0d0e0f, rk_round=0.
- NK=8, key_in = last 8 words from key 000102...1e1f.
  - Round 1 = 10111213 14151617 18191a1b 1c1d1e1f.
  - Round 0 = 00010203...0e0f.
  - 15 handshakes total.
- Random rk_ready backpressure (NK=6): rk, rk_round and rk_last stay stable while stalled; sequence identical to the no-stall run.
- start pulsed mid-RUN at round 5: ignored and sequence unaffected. reset low at round 7: outputs return to reset values at once. A new start after release gives a correct full sequence.
- Macro test with INV_KEY_ZEROIZE_EN: after rk_last is accepted, rk==0 in IDLE. Without the macro, rk equals the last window contents.
